rx_arbiter_rr: RTL and testbench
================================

RX_ARBITER_RR -- requirements
Module: rx_arbiter_rr

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, named reset_n.
REQ-002 Parameter ID, default -1: parent router id, informational only, no functional effect.
REQ-003 Parameter N, default 5: number of sender channels, legal range 2..16.
REQ-004 Parameter SIZE, default 8: data item width in bits, legal range 1..64.
REQ-005 Parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-006 Ports, in order:
  clk             in   1              clock, rising edge
  reset_n         in   1              asynchronous reset, active-low
  fifo_push_req   in   N              two-phase request, one bit per channel
  fifo_push_ack   out  N              two-phase acknowledge, one bit per channel
  fifo_push_data  in   N*SIZE         channel k data at bits [k*SIZE+SIZE-1 : k*SIZE]
  fifo_write      out  1              one-cycle FIFO write strobe
  fifo_full       in   1              FIFO cannot accept a write this cycle
  fifo_data_in    out  SIZE           data written to the FIFO
  grant_idx       out  clog2(N)       index of the channel written by the current fifo_write
  pending         out  N              per-channel outstanding-request mask

Function
REQ-007 Combinational pending[k] = fifo_push_req[k] XOR fifo_push_ack[k].
REQ-008 Each rising clk edge with fifo_full=0 and pending nonzero, exactly one channel g SHALL be granted.
REQ-009 MODE 0: g = the first pending index at or after rr_ptr, searching upward and wrapping N-1 -> 0.
REQ-010 MODE 1: g = the lowest pending index; rr_ptr is unused.
REQ-011 On a grant, registered outputs SHALL update at that edge: fifo_write=1, fifo_data_in=channel g data, fifo_push_ack[g] toggled, grant_idx=g.
REQ-012 On a grant, rr_ptr SHALL become (g+1) mod N; at g=N-1 it wraps to 0.
REQ-013 No grant (fifo_full=1 or pending=0): fifo_write=0; fifo_data_in, grant_idx, ack and rr_ptr hold.
REQ-014 fifo_full is sampled at the same edge as the grant decision, with no lookahead; a full FIFO never receives a write.
REQ-015 Latency: a request toggle seen at edge t, with FIFO not full and no competitor, gives fifo_write high and ack toggled after edge t.
REQ-016 Throughput: one write per cycle while any channel is pending and fifo_full=0; back-to-back grants are allowed.
REQ-017 Only fifo_push_ack[g] SHALL toggle per cycle; other ack bits hold, even when they are pending.
REQ-018 A channel whose req toggles in the same cycle its previous ack toggled SHALL be pending next cycle; no request is lost or duplicated.
REQ-019 Fairness in MODE 0: a pending channel is granted within N grants of its request becoming pending.
REQ-020 Senders hold data stable while pending[k]=1; the block samples data only at grant.
REQ-021 A req toggle while already pending is a sender protocol violation; behaviour is undefined and it is not checked.

Reset
REQ-022 reset_n low SHALL immediately force fifo_push_ack=0, fifo_write=0, fifo_data_in=0, grant_idx=0, rr_ptr=0, regardless of clk.
REQ-023 Reset asserted mid-transfer SHALL abort it: no write is issued during or on the edge of reset.
REQ-024 After reset_n deasserts, any req bit equal to 1 SHALL count as pending.

Verification (N=5, SIZE=8, MODE 0 unless stated)
REQ-025 Single request: ch2 req 0->1 with data 0xA5, full=0 -> next edge: fifo_write=1, fifo_data_in=0xA5, grant_idx=2, ack[2]=1; following cycle fifo_write=0.
REQ-026 All five channels toggle together, data 0x10..0x14 -> five consecutive writes in order 0,1,2,3,4, then rr_ptr=0.
REQ-027 Round-robin wrap: rr_ptr=4, ch0 and ch3 pending -> ch0 granted, then ch3.
REQ-028 Full stall: ch1 pending, fifo_full=1 for 3 cycles -> no write and ack[1] unchanged; full drops -> write of ch1 on the next edge.
REQ-029 MODE 1: ch4 and ch1 pending continuously, ch1 re-toggling after every ack -> ch1 granted every cycle and ch4 starves.
REQ-030 Reset mid-stream: reset_n low during a 5-channel burst -> outputs 0 asynchronously; after release, channels with req=1 are served starting at ch0.

Source files
------------

// File: rtl/rx_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_arbiter_rr : N-channel two-phase handshake arbiter feeding one FIFO.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rx_arbiter_rr #(
  parameter int ID   = -1,
  parameter int N    = 5,
  parameter int SIZE = 8,
  parameter int MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N-1:0]          fifo_push_req,
  output logic [N-1:0]          fifo_push_ack,
  input  logic [N*SIZE-1:0]     fifo_push_data,
  output logic                  fifo_write,
  input  logic                  fifo_full,
  output logic [SIZE-1:0]       fifo_data_in,
  output logic [$clog2(N)-1:0]  grant_idx,
  output logic [N-1:0]          pending
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 16 || SIZE < 1 || SIZE > 64 || MODE < 0 || MODE > 1) begin : g_bad_param
    $error("rx_arbiter_rr (router %0d): illegal parameter set", ID);
  end

  logic [SIZE-1:0] ch_data [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign ch_data[k] = fifo_push_data[k*SIZE +: SIZE];
  end

  logic [N-1:0]    ack_q, ack_d;
  logic            write_q, write_d;
  logic [SIZE-1:0] data_q, data_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [IW:0]     base;
  logic [IW:0]     cand;
  logic            found;
  logic [IW-1:0]   gsel;

  assign pending = fifo_push_req ^ ack_q;

  // Search starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode;
  // the extra bit of cand absorbs the wrap before it is folded back below N.
  always_comb begin
    base  = (MODE == 0) ? {1'b0, rr_ptr_q} : '0;
    cand  = '0;
    found = 1'b0;
    gsel  = '0;
    for (int i = 0; i < N; i++) begin
      cand = base + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && pending[cand[IW-1:0]]) begin
        found = 1'b1;
        gsel  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    ack_d    = ack_q;
    write_d  = 1'b0;
    data_d   = data_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    if (found && !fifo_full) begin
      ack_d[gsel] = ~ack_q[gsel];
      write_d     = 1'b1;
      data_d      = ch_data[gsel];
      gidx_d      = gsel;
      rr_ptr_d    = (gsel == IW'(N-1)) ? '0 : gsel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= '0;
      write_q  <= 1'b0;
      data_q   <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      ack_q    <= ack_d;
      write_q  <= write_d;
      data_q   <= data_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign fifo_push_ack = ack_q;
  assign fifo_write    = write_q;
  assign fifo_data_in  = data_q;
  assign grant_idx     = gidx_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rx_arbiter_rr : arbiter bench, round-robin and fixed-priority DUTs.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rx_arbiter_rr;

  localparam int N    = 5;
  localparam int SIZE = 8;
  localparam int IW   = $clog2(N);

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  // index 0: MODE 0 instance, index 1: MODE 1 instance
  logic [N-1:0]      req  [2];
  logic [N*SIZE-1:0] din  [2];
  logic              full [2];
  logic [N-1:0]      ack  [2];
  logic              wr   [2];
  logic [SIZE-1:0]   dout [2];
  logic [IW-1:0]     gidx [2];
  logic [N-1:0]      pend [2];

  logic [N-1:0]      e_ack  [2];
  logic              e_wr   [2];
  logic [SIZE-1:0]   e_dat  [2];
  int                e_gidx [2];
  int                e_rr   [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rx_arbiter_rr #(.ID(3), .N(N), .SIZE(SIZE), .MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .fifo_push_req(req[0]), .fifo_push_ack(ack[0]), .fifo_push_data(din[0]),
    .fifo_write(wr[0]), .fifo_full(full[0]), .fifo_data_in(dout[0]),
    .grant_idx(gidx[0]), .pending(pend[0])
  );

  rx_arbiter_rr #(.ID(4), .N(N), .SIZE(SIZE), .MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .fifo_push_req(req[1]), .fifo_push_ack(ack[1]), .fifo_push_data(din[1]),
    .fifo_write(wr[1]), .fifo_full(full[1]), .fifo_data_in(dout[1]),
    .grant_idx(gidx[1]), .pending(pend[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner chosen straight from the rule: first pending channel scanning
  // upward from the pointer (mode 0) or from channel 0 (mode 1).
  function automatic int pick(input int mode, input logic [N-1:0] p, input int rr);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (mode == 0) ? (rr + i) % N : i;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int g;
    for (int d = 0; d < 2; d++) begin
      e_ack[d] = '0; e_wr[d] = 1'b0; e_dat[d] = '0; e_gidx[d] = 0; e_rr[d] = 0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset_n) begin
          e_ack[d] = '0; e_wr[d] = 1'b0; e_dat[d] = '0; e_gidx[d] = 0; e_rr[d] = 0;
        end else begin
          g = pick(d, req[d] ^ e_ack[d], e_rr[d]);
          if (g >= 0 && !full[d]) begin
            e_wr[d]    = 1'b1;
            e_dat[d]   = din[d][g*SIZE +: SIZE];
            e_ack[d][g] = ~e_ack[d][g];
            e_gidx[d]  = g;
            e_rr[d]    = (g + 1) % N;
          end else begin
            e_wr[d] = 1'b0;
          end
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d fifo_write", d),   64'(wr[d]),   64'(e_wr[d]));
        chk($sformatf("dut%0d fifo_data_in", d), 64'(dout[d]), 64'(e_dat[d]));
        chk($sformatf("dut%0d grant_idx", d),    64'(gidx[d]), 64'(e_gidx[d]));
        chk($sformatf("dut%0d ack", d),          64'(ack[d]),  64'(e_ack[d]));
        chk($sformatf("dut%0d pending", d),      64'(pend[d]), 64'(req[d] ^ e_ack[d]));
      end
    end
  end

  task automatic tog(input int d, input int k, input logic [SIZE-1:0] v);
    req[d][k] = ~req[d][k];
    din[d][k*SIZE +: SIZE] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; din[d] = '0; full[d] = 1'b0;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; din[d] = '0; full[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset write", 64'(wr[0]), 64'(0));
    chk("reset data",  64'(dout[0]), 64'(0));
    chk("reset gidx",  64'(gidx[0]), 64'(0));
    chk("reset ack",   64'(ack[0]), 64'(0));
    reset_n = 1'b1;

    // single request on channel 2
    @(negedge clk); tog(0, 2, 8'hA5);
    @(posedge clk); #2;
    chk("single write", 64'(wr[0]), 64'(1));
    chk("single data",  64'(dout[0]), 64'hA5);
    chk("single gidx",  64'(gidx[0]), 64'(2));
    chk("single ack2",  64'(ack[0][2]), 64'(1));
    @(posedge clk); #2;
    chk("single idle", 64'(wr[0]), 64'(0));

    // all five channels together from a fresh pointer
    do_reset();
    @(negedge clk);
    for (int k = 0; k < N; k++) tog(0, k, 8'(8'h10 + k));
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #2;
      chk($sformatf("burst gidx %0d", i), 64'(gidx[0]), 64'(i));
      chk($sformatf("burst data %0d", i), 64'(dout[0]), 64'(8'h10 + i));
    end
    chk("burst rr_ptr", 64'(dut0.rr_ptr_q), 64'(0));

    // pointer to 4, then ch0 and ch3 compete
    @(negedge clk); tog(0, 3, 8'h33);
    @(posedge clk); #2;
    chk("wrap pre gidx", 64'(gidx[0]), 64'(3));
    @(negedge clk); tog(0, 0, 8'h50); tog(0, 3, 8'h53);
    @(posedge clk); #2;
    chk("wrap first", 64'(gidx[0]), 64'(0));
    @(posedge clk); #2;
    chk("wrap second", 64'(gidx[0]), 64'(3));

    // full stall on ch1
    @(negedge clk); full[0] = 1'b1; tog(0, 1, 8'h61);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("stall write", 64'(wr[0]), 64'(0));
      chk("stall ack1",  64'(ack[0][1]), 64'(1));
    end
    @(negedge clk); full[0] = 1'b0;
    @(posedge clk); #2;
    chk("stall release write", 64'(wr[0]), 64'(1));
    chk("stall release gidx",  64'(gidx[0]), 64'(1));
    chk("stall release data",  64'(dout[0]), 64'h61);

    // fixed priority: ch1 re-requests every cycle, ch4 starves
    do_reset();
    @(negedge clk); tog(1, 4, 8'h44); tog(1, 1, 8'h11);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      chk("prio gidx",  64'(gidx[1]), 64'(1));
      chk("prio write", 64'(wr[1]), 64'(1));
      chk("prio ch4 pending", 64'(pend[1][4]), 64'(1));
      @(negedge clk);
      if (req[1][1] == e_ack[1][1]) tog(1, 1, 8'h11);
    end

    // reset in the middle of a burst
    do_reset();
    @(negedge clk);
    for (int k = 0; k < N; k++) tog(0, k, 8'(8'h20 + k));
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b0; #1;
    chk("async rst write", 64'(wr[0]), 64'(0));
    chk("async rst data",  64'(dout[0]), 64'(0));
    chk("async rst gidx",  64'(gidx[0]), 64'(0));
    chk("async rst ack",   64'(ack[0]), 64'(0));
    @(posedge clk); #2;
    chk("rst edge write", 64'(wr[0]), 64'(0));
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #2;
    chk("post rst write", 64'(wr[0]), 64'(1));
    chk("post rst gidx",  64'(gidx[0]), 64'(0));
    chk("post rst data",  64'(dout[0]), 64'h20);

    // randomized traffic with random back-pressure on both instances
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        full[d] = ($urandom_range(3) == 0);
        for (int k = 0; k < N; k++) begin
          if (req[d][k] == e_ack[d][k] && $urandom_range(4) < 2)
            tog(d, k, 8'($urandom));
        end
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
